// File: rtl/seq_alu.sv
// seq_alu: clocked WIDTH-bit ALU with a start/busy/done handshake.
// ADD, SUB and the logic ops finish on the edge that accepts start.
// MUL (shift-add) and DIV (restoring) take WIDTH iteration edges and then
// write the result. Results and flags stay registered until the next
// completion.
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   start, select     request and opcode (0 ADD, 1 SUB, 2 MUL, 3 DIV,
//                     4 AND, 5 OR, 6 XOR, 7 NOT a)
//   a, b              operands (unsigned for MUL/DIV)
//   busy, done        iteration in progress / one-cycle completion pulse
//   result, result_hi low result; high product or remainder
//   zero, carry, sign, parity, overflow, div_by_zero   registered flags
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start; single-cycle ops complete from here
// ITER  | one MUL/DIV step per edge, counter runs WIDTH down to 1
module seq_alu #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       select,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             zero,
    output logic             carry,
    output logic             sign,
    output logic             parity,
    output logic             overflow,
    output logic             div_by_zero
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_MUL = 3'd2;
    localparam logic [2:0] OP_DIV = 3'd3;
    localparam logic [2:0] OP_AND = 3'd4;
    localparam logic [2:0] OP_OR  = 3'd5;
    localparam logic [2:0] OP_XOR = 3'd6;
    localparam logic [2:0] OP_NOT = 3'd7;

    typedef enum logic {
        IDLE = 1'b0,
        ITER = 1'b1
    } state_t;

    state_t state, state_next;

    logic [CNT_W-1:0] cnt;
    logic             is_div;
    logic [WIDTH-1:0] a_lat;
    logic [WIDTH-1:0] b_lat;
    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] acc_lo;

    logic accept;
    logic iter_op;
    logic finish;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // start is only looked at in IDLE, so latched operands cannot be
    // disturbed while an iteration runs.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        finish     = 1'b0;
        iter_op    = (select == OP_MUL) || (select == OP_DIV);
        case (state)
            IDLE: begin
                if (start) begin
                    accept = 1'b1;
                    if (iter_op) state_next = ITER;
                end
            end
            ITER: begin
                if (cnt == CNT_W'(1)) begin
                    finish     = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // single-cycle ops, computed straight from the inputs
    logic [WIDTH:0]   add_full;
    logic [WIDTH:0]   sub_full;
    logic [WIDTH-1:0] imm_res;
    logic             imm_carry;
    logic             imm_ovf;

    always_comb begin
        add_full  = {1'b0, a} + {1'b0, b};
        sub_full  = {1'b0, a} - {1'b0, b};
        imm_res   = '0;
        imm_carry = 1'b0;
        imm_ovf   = 1'b0;
        case (select)
            OP_ADD: begin
                imm_res   = add_full[WIDTH-1:0];
                imm_carry = add_full[WIDTH];
                imm_ovf   = (a[WIDTH-1] == b[WIDTH-1]) &&
                            (add_full[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                imm_res   = sub_full[WIDTH-1:0];
                imm_carry = sub_full[WIDTH];   // borrow out == (a < b)
                imm_ovf   = (a[WIDTH-1] != b[WIDTH-1]) &&
                            (sub_full[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND:  imm_res = a & b;
            OP_OR:   imm_res = a | b;
            OP_XOR:  imm_res = a ^ b;
            OP_NOT:  imm_res = ~a;
            default: imm_res = '0;
        endcase
    end

    // One iteration step. acc_hi/acc_lo hold {partial product, multiplier}
    // for MUL and {partial remainder, dividend/quotient} for DIV.
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH-1:0] div_sub;
    logic             div_ge;
    logic [WIDTH-1:0] step_hi;
    logic [WIDTH-1:0] step_lo;

    always_comb begin
        mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, a_lat} : '0);
        div_shift = {acc_hi, acc_lo[WIDTH-1]};
        div_ge    = div_shift >= {1'b0, b_lat};
        // remainder stays below b, so the difference fits in WIDTH bits
        div_sub   = div_shift[WIDTH-1:0] - b_lat;
        if (is_div) begin
            step_hi = div_ge ? div_sub : div_shift[WIDTH-1:0];
            step_lo = {acc_lo[WIDTH-2:0], div_ge};
        end else begin
            step_hi = mul_sum[WIDTH:1];
            step_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt         <= '0;
            is_div      <= 1'b0;
            a_lat       <= '0;
            b_lat       <= '0;
            acc_hi      <= '0;
            acc_lo      <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            result      <= '0;
            result_hi   <= '0;
            zero        <= 1'b0;
            carry       <= 1'b0;
            sign        <= 1'b0;
            parity      <= 1'b0;
            overflow    <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            // busy rises one edge after acceptance, giving WIDTH-1 busy cycles
            busy <= (state == ITER) && !finish;

            if (accept) begin
                a_lat  <= a;
                b_lat  <= b;
                is_div <= (select == OP_DIV);
                if (iter_op) begin
                    cnt    <= CNT_W'(WIDTH);
                    acc_hi <= '0;
                    acc_lo <= (select == OP_DIV) ? a : b;
                end else begin
                    result      <= imm_res;
                    result_hi   <= '0;
                    zero        <= (imm_res == '0);
                    carry       <= imm_carry;
                    sign        <= imm_res[WIDTH-1];
                    parity      <= ~^imm_res;
                    overflow    <= imm_ovf;
                    div_by_zero <= 1'b0;
                    done        <= 1'b1;
                end
            end

            if (state == ITER) begin
                acc_hi <= step_hi;
                acc_lo <= step_lo;
                cnt    <= cnt - CNT_W'(1);
                if (finish) begin
                    result      <= step_lo;
                    result_hi   <= step_hi;
                    zero        <= (step_lo == '0);
                    carry       <= !is_div && (|step_hi);
                    sign        <= step_lo[WIDTH-1];
                    parity      <= ~^step_lo;
                    overflow    <= 1'b0;
                    div_by_zero <= is_div && (b_lat == '0);
                    done        <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// Testbench for seq_alu: directed WIDTH=8 cases plus random ops at WIDTH=4
// and WIDTH=16, scored against a reference model through per-instance
// expectation queues.
module tb_seq_alu;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    typedef struct packed {
        logic [31:0] res;
        logic [31:0] hi;
        logic [5:0]  flg;   // {zero, carry, sign, parity, overflow, div_by_zero}
    } exp_t;

    exp_t q8[$];
    exp_t q4[$];
    exp_t q16[$];

    int n_tests = 0;
    int n_fail  = 0;

    // ---------------- DUT instances ----------------
    logic        start8, busy8, done8, z8, c8, s8, p8, v8, dz8;
    logic [2:0]  sel8;
    logic [7:0]  a8, b8, res8, hi8;

    logic        start4, busy4, done4, z4, c4, s4, p4, v4, dz4;
    logic [2:0]  sel4;
    logic [3:0]  a4, b4, res4, hi4;

    logic        start16, busy16, done16, z16, c16, s16, p16, v16, dz16;
    logic [2:0]  sel16;
    logic [15:0] a16, b16, res16, hi16;

    seq_alu #(.WIDTH(8)) u_alu8 (
        .clk(clk), .rst(rst), .start(start8), .select(sel8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .result(res8), .result_hi(hi8),
        .zero(z8), .carry(c8), .sign(s8), .parity(p8), .overflow(v8),
        .div_by_zero(dz8)
    );

    seq_alu #(.WIDTH(4)) u_alu4 (
        .clk(clk), .rst(rst), .start(start4), .select(sel4), .a(a4), .b(b4),
        .busy(busy4), .done(done4), .result(res4), .result_hi(hi4),
        .zero(z4), .carry(c4), .sign(s4), .parity(p4), .overflow(v4),
        .div_by_zero(dz4)
    );

    seq_alu #(.WIDTH(16)) u_alu16 (
        .clk(clk), .rst(rst), .start(start16), .select(sel16), .a(a16), .b(b16),
        .busy(busy16), .done(done16), .result(res16), .result_hi(hi16),
        .zero(z16), .carry(c16), .sign(s16), .parity(p16), .overflow(v16),
        .div_by_zero(dz16)
    );

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // reference model, plain integer arithmetic at 64 bits
    function automatic exp_t model(input int w, input logic [2:0] op,
                                   input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        logic [63:0] m, full, r, h;
        logic        c, v, dz;
        m  = (64'd1 << w) - 64'd1;
        h  = '0;
        c  = 1'b0;
        v  = 1'b0;
        dz = 1'b0;
        r  = '0;
        case (op)
            3'd0: begin
                full = {32'd0, a} + {32'd0, b};
                r    = full & m;
                c    = full[w];
                v    = (a[w-1] == b[w-1]) && (r[w-1] != a[w-1]);
            end
            3'd1: begin
                r = ({32'd0, a} - {32'd0, b}) & m;
                c = (a < b);
                v = (a[w-1] != b[w-1]) && (r[w-1] != a[w-1]);
            end
            3'd2: begin
                full = {32'd0, a} * {32'd0, b};
                r    = full & m;
                h    = (full >> w) & m;
                c    = (h != 64'd0);
            end
            3'd3: begin
                if (b == 32'd0) begin
                    r  = m;
                    h  = {32'd0, a};
                    dz = 1'b1;
                end else begin
                    r = {32'd0, a / b};
                    h = {32'd0, a % b};
                end
            end
            3'd4: r = {32'd0, a & b};
            3'd5: r = {32'd0, a | b};
            3'd6: r = {32'd0, a ^ b};
            default: r = ~{32'd0, a} & m;
        endcase
        e.res = r[31:0];
        e.hi  = h[31:0];
        e.flg = {(r == 64'd0), c, r[w-1], ~^r, v, dz};
        return e;
    endfunction

    // ---------------- scoreboard monitors ----------------
    exp_t e8, e4, e16;

    always @(negedge clk) begin
        if (done8) begin
            if (q8.size() == 0) check("w8_extra_done", 64'd1, 64'd0);
            else begin
                e8 = q8.pop_front();
                check("w8_result", 64'(res8), 64'(e8.res));
                check("w8_result_hi", 64'(hi8), 64'(e8.hi));
                check("w8_flags", 64'({z8, c8, s8, p8, v8, dz8}), 64'(e8.flg));
            end
        end
    end

    always @(negedge clk) begin
        if (done4) begin
            if (q4.size() == 0) check("w4_extra_done", 64'd1, 64'd0);
            else begin
                e4 = q4.pop_front();
                check("w4_result", 64'(res4), 64'(e4.res));
                check("w4_result_hi", 64'(hi4), 64'(e4.hi));
                check("w4_flags", 64'({z4, c4, s4, p4, v4, dz4}), 64'(e4.flg));
            end
        end
    end

    always @(negedge clk) begin
        if (done16) begin
            if (q16.size() == 0) check("w16_extra_done", 64'd1, 64'd0);
            else begin
                e16 = q16.pop_front();
                check("w16_result", 64'(res16), 64'(e16.res));
                check("w16_result_hi", 64'(hi16), 64'(e16.hi));
                check("w16_flags", 64'({z16, c16, s16, p16, v16, dz16}), 64'(e16.flg));
            end
        end
    end

    // ---------------- driver ----------------
    function automatic logic done_of(input int w);
        case (w)
            4:       return done4;
            16:      return done16;
            default: return done8;
        endcase
    endfunction

    function automatic logic busy_of(input int w);
        case (w)
            4:       return busy4;
            16:      return busy16;
            default: return busy8;
        endcase
    endfunction

    // Issues one op and waits for done. n counts cycles after the accepting
    // edge: done shows up in the cycle after the writing edge, which is the
    // accepting edge itself for single-cycle ops and WIDTH edges later for
    // MUL/DIV. With disturb set, a/b/select/start are scrambled while busy.
    task automatic run_op(input int w, input logic [2:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input bit disturb);
        int n, nb, lat_exp, busy_exp;
        bit iter;
        iter     = (op == 3'd2) || (op == 3'd3);
        lat_exp  = iter ? w + 1 : 1;
        busy_exp = iter ? w - 1 : 0;
        @(negedge clk);
        case (w)
            4:  begin start4 = 1'b1;  sel4 = op;  a4 = a[3:0];   b4 = b[3:0];   q4.push_back(model(4, op, a, b));  end
            16: begin start16 = 1'b1; sel16 = op; a16 = a[15:0]; b16 = b[15:0]; q16.push_back(model(16, op, a, b)); end
            default: begin start8 = 1'b1; sel8 = op; a8 = a[7:0]; b8 = b[7:0]; q8.push_back(model(8, op, a, b)); end
        endcase
        @(negedge clk);
        start4 = 1'b0; start8 = 1'b0; start16 = 1'b0;
        n  = 1;
        nb = 0;
        while (1) begin
            if (busy_of(w)) nb++;
            if (done_of(w) || n >= 64) break;
            if (disturb && busy8) begin
                a8     = 8'($urandom);
                b8     = 8'($urandom);
                sel8   = 3'($urandom);
                start8 = ~start8;
            end
            @(negedge clk);
            n++;
        end
        start8 = 1'b0;
        check($sformatf("w%0d_op%0d_done_cycle", w, op), 64'(n), 64'(lat_exp));
        check($sformatf("w%0d_op%0d_busy_cycles", w, op), 64'(nb), 64'(busy_exp));
        @(negedge clk);
        check($sformatf("w%0d_op%0d_done_pulse", w, op), 64'(done_of(w)), 64'd0);
    endtask

    task automatic check_zero8(input string tag);
        check({tag, "_result"}, 64'(res8), 64'd0);
        check({tag, "_result_hi"}, 64'(hi8), 64'd0);
        check({tag, "_flags"}, 64'({z8, c8, s8, p8, v8, dz8}), 64'd0);
        check({tag, "_busy_done"}, 64'({busy8, done8}), 64'd0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int   seen;
        logic [31:0] ra, rb, mask;
        logic [2:0]  rop;

        rst = 1'b1;
        start8 = 0;  sel8 = 0;  a8 = 0;  b8 = 0;
        start4 = 0;  sel4 = 0;  a4 = 0;  b4 = 0;
        start16 = 0; sel16 = 0; a16 = 0; b16 = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_zero8("reset");

        run_op(8, 3'd0, 32'h7F, 32'h01, 0);
        run_op(8, 3'd1, 32'h05, 32'h07, 0);
        run_op(8, 3'd0, 32'hFF, 32'h01, 0);
        run_op(8, 3'd2, 32'h10, 32'h20, 1);
        run_op(8, 3'd3, 32'd100, 32'd7, 0);
        run_op(8, 3'd3, 32'h55, 32'h00, 0);

        // reset three cycles into a MUL: no completion, outputs cleared
        @(negedge clk);
        start8 = 1'b1; sel8 = 3'd2; a8 = 8'hAB; b8 = 8'hCD;
        @(negedge clk);
        start8 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_zero8("rst_mid_mul");
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (done8) seen = 1;
        end
        check("rst_mid_mul_no_done", 64'(seen), 64'd0);

        // XOR with start held: re-issued on every idle edge
        @(negedge clk);
        start8 = 1'b1; sel8 = 3'd6; a8 = 8'hF0; b8 = 8'h3C;
        repeat (4) q8.push_back(model(8, 3'd6, 32'hF0, 32'h3C));
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("xor_held_done", 64'(done8), 64'd1);
            check("xor_held_busy", 64'(busy8), 64'd0);
        end
        start8 = 1'b0;
        @(negedge clk);
        check("xor_held_release", 64'(done8), 64'd0);

        // random ops at WIDTH=4 and WIDTH=16
        for (int wi = 0; wi < 2; wi++) begin
            int w;
            w    = (wi == 0) ? 4 : 16;
            mask = (32'd1 << w) - 32'd1;
            for (int i = 0; i < 1000; i++) begin
                rop = 3'($urandom_range(0, 3));
                ra  = $urandom & mask;
                rb  = ($urandom_range(0, 7) == 0) ? 32'd0 : ($urandom & mask);
                run_op(w, rop, ra, rb, 0);
            end
        end

        repeat (4) @(negedge clk);
        check("q8_drained", 64'(q8.size()), 64'd0);
        check("q4_drained", 64'(q4.size()), 64'd0);
        check("q16_drained", 64'(q16.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
